mmio_port_responder: RTL and testbench

- Memory-mapped I/O responder on the processor data bus, parallel to the data RAM.
- Decodes load/store accesses inside a 32-byte window and owns:
  - the 32-bit output port register;
  - the synchronized 8-bit input port, with sticky rising-edge flags and an edge mask;
  - a down-counting timer.
- Top level muxes ReadData against RAM using Selected; IRQ is exported for a future interrupt path.

---
 rtl/mmio_port_responder.sv | 160 ++++++++++++++++
 tb/tb_mmio_port_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder: output port, synchronized input port with sticky
// rising-edge flags, and a down-counting timer in a 32-byte window beside data RAM.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'h1001_0100,
  parameter int          PORT_IN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              Address,
  input  logic [31:0]              WriteData,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic                     Selected,
  output logic [31:0]              ReadData,
  output logic [31:0]              PortOut,
  output logic                     IRQ
);

  localparam int W = PORT_IN_WIDTH;

  typedef enum logic [2:0] {
    REG_PORT_OUT    = 3'd0,
    REG_PORT_IN     = 3'd1,
    REG_EDGE_FLAGS  = 3'd2,
    REG_TIMER_CTRL  = 3'd3,
    REG_TIMER_LOAD  = 3'd4,
    REG_TIMER_COUNT = 3'd5,
    REG_EDGE_MASK   = 3'd6,
    REG_RESERVED    = 3'd7
  } reg_idx_e;

  reg_idx_e reg_idx;
  logic     wr_en;
  logic     wr_port_out, wr_flags, wr_ctrl, wr_load, wr_mask;
  logic     unused_addr_bits;

  logic [31:0]  port_out_q, port_out_d;
  logic [W-1:0] sync1_q, sync2_q, prev_q;
  logic [W-1:0] flags_q, flags_d;
  logic [W-1:0] mask_q, mask_d;
  logic [W-1:0] rise;
  logic         en_q, en_d;
  logic         auto_q, auto_d;
  logic         expired_q, expired_d;
  logic         expire_set;
  logic [31:0]  load_q, load_d;
  logic [31:0]  count_q, count_d;
  logic         irq_q, irq_d;

  logic [31:0]  port_in_ext, flags_ext, mask_ext, ctrl_ext;

  // Word select; byte offset bits are don't-care.
  assign Selected         = (Address[31:5] == BASE_ADDR[31:5]);
  assign reg_idx          = reg_idx_e'(Address[4:2]);
  assign unused_addr_bits = ^Address[1:0];
  assign wr_en            = Selected & MemWrite;

  assign wr_port_out = wr_en && (reg_idx == REG_PORT_OUT);
  assign wr_flags    = wr_en && (reg_idx == REG_EDGE_FLAGS);
  assign wr_ctrl     = wr_en && (reg_idx == REG_TIMER_CTRL);
  assign wr_load     = wr_en && (reg_idx == REG_TIMER_LOAD);
  assign wr_mask     = wr_en && (reg_idx == REG_EDGE_MASK);

  assign rise = sync2_q & ~prev_q;

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    port_out_d = wr_port_out ? WriteData : port_out_q;
    mask_d     = wr_mask ? WriteData[W-1:0] : mask_q;
    // A rise arriving in the same cycle as its W1C clear keeps the flag set.
    flags_d    = (flags_q & ~(wr_flags ? WriteData[W-1:0] : {W{1'b0}})) | rise;
    irq_d      = expired_q | (|(flags_q & mask_q));
    en_d       = wr_ctrl ? WriteData[0] : en_q;
    auto_d     = wr_ctrl ? WriteData[1] : auto_q;
  end

  always_comb begin
    load_d     = load_q;
    count_d    = count_q;
    expire_set = 1'b0;
    if (wr_load) begin
      load_d  = WriteData;
      count_d = WriteData;
    end else if (en_q) begin
      if (count_q != 32'd0) begin
        count_d    = count_q - 32'd1;
        expire_set = (count_q == 32'd1);
      end else if (auto_q) begin
        count_d = load_q;
      end
    end
    // The 1->0 expiry beats a simultaneous software clear.
    expired_d = expire_set | (expired_q & ~(wr_ctrl & WriteData[8]));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      flags_q    <= '0;
      mask_q     <= '0;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      expired_q  <= 1'b0;
      load_q     <= '0;
      count_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      port_out_q <= port_out_d;
      sync1_q    <= PortIn;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      flags_q    <= flags_d;
      mask_q     <= mask_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      expired_q  <= expired_d;
      load_q     <= load_d;
      count_q    <= count_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    port_in_ext          = '0;
    port_in_ext[W-1:0]   = sync2_q;
    flags_ext            = '0;
    flags_ext[W-1:0]     = flags_q;
    mask_ext             = '0;
    mask_ext[W-1:0]      = mask_q;
    ctrl_ext             = {23'd0, expired_q, 6'd0, auto_q, en_q};
  end

  // Reads return pre-edge state, so a concurrent store is not visible yet.
  always_comb begin
    ReadData = 32'h0;
    if (Selected && MemRead) begin
      case (reg_idx)
        REG_PORT_OUT:    ReadData = port_out_q;
        REG_PORT_IN:     ReadData = port_in_ext;
        REG_EDGE_FLAGS:  ReadData = flags_ext;
        REG_TIMER_CTRL:  ReadData = ctrl_ext;
        REG_TIMER_LOAD:  ReadData = load_q;
        REG_TIMER_COUNT: ReadData = count_q;
        REG_EDGE_MASK:   ReadData = mask_ext;
        default:         ReadData = 32'h0;
      endcase
    end
  end

  assign PortOut = port_out_q;
  assign IRQ     = irq_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder: directed register-map scenarios
// followed by randomized traffic compared against a cycle-level reference model.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0100;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic        Selected;
  logic [31:0] ReadData;
  logic [31:0] PortOut;
  logic        IRQ;

  mmio_port_responder #(
    .BASE_ADDR    (BASE),
    .PORT_IN_WIDTH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .PortIn   (PortIn),
    .Selected (Selected),
    .ReadData (ReadData),
    .PortOut  (PortOut),
    .IRQ      (IRQ)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] pin_cur;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: register contents plus a history of sampled input values.
  logic [31:0] m_port_out, m_load, m_count;
  logic [7:0]  m_flags, m_mask;
  logic        m_en, m_ar, m_exp, m_irq;
  logic [7:0]  m_samples[$];   // [0] newest edge sample; [1] is what PORT_IN shows

  function automatic void m_reset();
    m_port_out = '0; m_load = '0; m_count = '0;
    m_flags = '0; m_mask = '0;
    m_en = 1'b0; m_ar = 1'b0; m_exp = 1'b0; m_irq = 1'b0;
    m_samples = {8'h00, 8'h00, 8'h00};
  endfunction

  function automatic logic in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd32);
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] off;
    if (!(in_window(Address) && MemRead)) return 32'h0;
    off = (Address - BASE) & 32'h1C;
    case (off)
      32'h00: return m_port_out;
      32'h04: return {24'h0, m_samples[1]};
      32'h08: return {24'h0, m_flags};
      32'h0C: return {23'h0, m_exp, 6'h0, m_ar, m_en};
      32'h10: return m_load;
      32'h14: return m_count;
      32'h18: return {24'h0, m_mask};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_step();
    logic [31:0] off;
    logic        we;
    logic [7:0]  newly_high;
    logic [31:0] n_count, n_load;
    logic        n_exp, fired;
    we  = in_window(Address) && MemWrite;
    off = (Address - BASE) & 32'h1C;
    newly_high = m_samples[1] & ~m_samples[2];

    n_load = m_load; n_count = m_count; fired = 1'b0;
    if (we && off == 32'h10) begin
      n_load = WriteData; n_count = WriteData;
    end else if (m_en && m_count > 0) begin
      n_count = m_count - 1;
      fired = (m_count == 1);
    end else if (m_en && m_ar) begin
      n_count = m_load;
    end
    n_exp = fired ? 1'b1 : ((we && off == 32'h0C && WriteData[8]) ? 1'b0 : m_exp);

    m_irq = m_exp || ((m_flags & m_mask) != 8'h0);
    if (we && off == 32'h08) m_flags = m_flags & ~WriteData[7:0];
    m_flags = m_flags | newly_high;
    if (we && off == 32'h00) m_port_out = WriteData;
    if (we && off == 32'h18) m_mask = WriteData[7:0];
    if (we && off == 32'h0C) begin
      m_en = WriteData[0]; m_ar = WriteData[1];
    end
    m_load = n_load; m_count = n_count; m_exp = n_exp;
    m_samples.push_front(PortIn);
    void'(m_samples.pop_back());
  endfunction

  // Called at posedge+1: drive, let combinational logic settle.
  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic mw, input logic mr);
    Address = a; WriteData = wd; MemWrite = mw; MemRead = mr; PortIn = pin_cur;
    #2;
  endtask

  // Compare outputs against the model, then advance one edge.
  task automatic tick();
    check("sel", {31'b0, Selected}, {31'b0, in_window(Address)});
    check("rdata", ReadData, m_read());
    check("port_out", PortOut, m_port_out);
    check("irq", {31'b0, IRQ}, {31'b0, m_irq});
    @(posedge clk);
    if (reset) m_step();
    else m_reset();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    drive(a, wd, 1'b1, 1'b0);
    tick();
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
    drive(a, 32'h0, 1'b0, 1'b1);
    check(tag, ReadData, exp);
    tick();
  endtask

  // Caller has already driven inputs for this cycle; reset lands between edges.
  task automatic pulse_reset();
    reset = 1'b0;
    m_reset();
    #1;
    check("rst_port_out", PortOut, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);
    check("rst_rdata", ReadData, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; pin_cur = 8'h00;
    Address = BASE; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b1; PortIn = 8'h00;
    #1 reset = 1'b0;
    m_reset();
    #1;
    check("reset_port_out", PortOut, 32'h0);
    check("reset_irq", {31'b0, IRQ}, 32'h0);
    check("reset_rdata", ReadData, 32'h0);
    check("reset_sel", {31'b0, Selected}, 32'h1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Output port and window decode
    wr(BASE, 32'hDEAD_BEEF);
    drive(BASE, 32'h0, 1'b0, 1'b1);
    check("po_out", PortOut, 32'hDEAD_BEEF);
    check("po_read", ReadData, 32'hDEAD_BEEF);
    check("po_sel", {31'b0, Selected}, 32'h1);
    tick();
    drive(32'h1001_0200, 32'h1234_5678, 1'b1, 1'b0);
    check("outside_sel", {31'b0, Selected}, 32'h0);
    tick();
    drive(32'h1001_0200, 32'h0, 1'b0, 1'b1);
    check("outside_po", PortOut, 32'hDEAD_BEEF);
    check("outside_rd", ReadData, 32'h0);
    tick();

    // Input synchronizer, edge flags, mask and IRQ
    pin_cur = 8'h05;
    rd_chk(BASE + 32'h04, 32'h00, "pin_e0");
    rd_chk(BASE + 32'h04, 32'h00, "pin_e1");
    rd_chk(BASE + 32'h08, 32'h00, "flags_e2");
    rd_chk(BASE + 32'h04, 32'h05, "pin_e3");
    rd_chk(BASE + 32'h08, 32'h05, "flags_e4");
    wr(BASE + 32'h18, 32'h04);
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("irq_lag", {31'b0, IRQ}, 32'h0);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("irq_set", {31'b0, IRQ}, 32'h1);
    tick();
    wr(BASE + 32'h08, 32'h04);
    drive(BASE + 32'h08, 32'h0, 1'b0, 1'b1);
    check("flags_w1c", ReadData, 32'h01);
    check("irq_still", {31'b0, IRQ}, 32'h1);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("irq_clear", {31'b0, IRQ}, 32'h0);
    tick();

    // Auto-reload timer
    wr(BASE + 32'h10, 32'd3);
    wr(BASE + 32'h0C, 32'h3);
    rd_chk(BASE + 32'h14, 32'd3, "ar_c3");
    rd_chk(BASE + 32'h14, 32'd2, "ar_c2");
    rd_chk(BASE + 32'h14, 32'd1, "ar_c1");
    rd_chk(BASE + 32'h14, 32'd0, "ar_c0");
    rd_chk(BASE + 32'h0C, 32'h103, "ar_exp");
    rd_chk(BASE + 32'h14, 32'd2, "ar_c2b");
    rd_chk(BASE + 32'h14, 32'd1, "ar_c1b");
    rd_chk(BASE + 32'h14, 32'd0, "ar_c0b");
    wr(BASE + 32'h0C, 32'h103);
    rd_chk(BASE + 32'h0C, 32'h003, "exp_cleared");
    wr(BASE + 32'h0C, 32'h103);
    rd_chk(BASE + 32'h0C, 32'h103, "exp_wins");

    // One-shot timer and mid-count reload
    wr(BASE + 32'h0C, 32'h101);
    wr(BASE + 32'h10, 32'd2);
    rd_chk(BASE + 32'h14, 32'd2, "os_c2");
    rd_chk(BASE + 32'h14, 32'd1, "os_c1");
    rd_chk(BASE + 32'h14, 32'd0, "os_c0");
    rd_chk(BASE + 32'h0C, 32'h101, "os_exp");
    wr(BASE + 32'h0C, 32'h101);
    rd_chk(BASE + 32'h0C, 32'h001, "os_noexp");
    wr(BASE + 32'h10, 32'd4);
    rd_chk(BASE + 32'h14, 32'd4, "rl_c4");
    wr(BASE + 32'h10, 32'd5);
    rd_chk(BASE + 32'h14, 32'd5, "rl_c5");

    // Asynchronous reset mid-count, then edge detect of an input already high
    wr(BASE, 32'hA5A5_A5A5);
    wr(BASE + 32'h18, 32'hFF);
    wr(BASE + 32'h10, 32'd200);
    pin_cur = 8'h80;
    wr(BASE + 32'h0C, 32'h3);
    drive(BASE + 32'h14, 32'h0, 1'b0, 1'b1);
    check("pre_rst_irq", {31'b0, IRQ}, 32'h1);
    check("pre_rst_count", ReadData, 32'd199);
    pulse_reset();
    rd_chk(BASE + 32'h08, 32'h00, "post_flags_e1");
    rd_chk(BASE + 32'h04, 32'h00, "post_pin_e2");
    rd_chk(BASE + 32'h04, 32'h80, "post_pin_e3");
    rd_chk(BASE + 32'h08, 32'h80, "post_flags");

    // Read-only / reserved writes, MemRead gating, read-during-write
    wr(BASE + 32'h10, 32'd9);
    wr(BASE + 32'h14, 32'h77);
    rd_chk(BASE + 32'h14, 32'd9, "ro_count");
    wr(BASE + 32'h1C, 32'hFFFF_FFFF);
    rd_chk(BASE + 32'h1C, 32'h0, "rsvd_read");
    rd_chk(BASE + 32'h14, 32'd9, "ro_count2");
    wr(BASE, 32'h0BAD_F00D);
    drive(BASE, 32'h0, 1'b0, 1'b0);
    check("no_memread", ReadData, 32'h0);
    tick();
    drive(BASE, 32'h1111_2222, 1'b1, 1'b1);
    check("rw_old", ReadData, 32'h0BAD_F00D);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("rw_new", PortOut, 32'h1111_2222);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, wd;
      if ($urandom_range(0, 15) == 0) pin_cur = 8'($urandom);
      if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, 31));
      else a = $urandom;
      if ($urandom_range(0, 1) == 1) wd = 32'($urandom_range(0, 6));
      else wd = $urandom;
      drive(a, wd, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
      tick();
      if (i == 1500) begin
        drive(BASE + 32'h14, 32'h0, 1'b0, 1'b1);
        pulse_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
